// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types and constants for the fetch stage and later pipeline registers.
package pipe_pkg;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} fetch_state_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0064;
    localparam int INSN_W = 32;
    localparam logic [INSN_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, clear-valid and hold; asynchronous reset.
module ifid_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ld,
    input  logic              i_clr,
    input  logic [INSN_W-1:0] i_inst,
    input  logic [XLEN-1:0]   i_pc,
    output logic [INSN_W-1:0] o_inst,
    output logic [XLEN-1:0]   o_pc,
    output logic              o_valid
);
    logic [INSN_W-1:0] r_inst;
    logic [XLEN-1:0]   r_pc;
    logic              r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst  <= NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_ld) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch and IF/ID capture with stall/flush/redirect/halt and fault detection.
// Optional FETCH_PERF_EN enables the perf_fetched / perf_bubbles counters (tied to 0 otherwise).
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    input  logic              resume,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [XLEN-1:0]   pc,
    output logic [INSN_W-1:0] dinst,
    output logic [XLEN-1:0]   dpc,
    output logic              dvalid,
    output logic              fault,
    output logic [1:0]        state,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
);
    fetch_state_t    r_state, w_state_nx;
    logic [XLEN-1:0] r_pc, w_pc_nx;
    logic            r_fault;
    logic            w_run, w_mis, w_oob, w_go, w_ld, w_hold, w_clr, w_set_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_fault <= r_fault | w_set_fault;
        end
    end

    // Word index out of range means the fetch address lies beyond instruction memory.
    assign w_mis = redirect && (redirect_pc[1:0] != 2'b00);
    assign w_oob = {2'b00, r_pc[XLEN-1:2]} >= XLEN'(IMEM_DEPTH);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            BOOT:    w_state_nx = RUN;
            RUN:     w_state_nx = (halt || w_mis || (!redirect && w_oob)) ? HALT : RUN;
            HALT:    w_state_nx = (resume && !r_fault) ? RUN : HALT;
            default: w_state_nx = BOOT;
        endcase
    end

    always_comb begin
        w_run       = r_state == RUN;
        w_go        = w_run && !halt && !w_mis;
        w_set_fault = w_go ? (!redirect && w_oob) : (w_run && !halt && w_mis);
        w_ld        = w_go && !redirect && !w_oob && !flush && !stall;
        w_hold      = w_go && !redirect && !w_oob && !flush && stall;
        w_clr       = (r_state == HALT) || (w_run && !w_ld && !w_hold);
        w_pc_nx     = !w_go              ? r_pc :
                      redirect           ? redirect_pc :
                      (w_oob || stall)   ? r_pc : r_pc + XLEN'(4);
    end

    ifid_reg #(.XLEN(XLEN)) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .i_ld    (w_ld),
        .i_clr   (w_clr),
        .i_inst  (imem_rdata),
        .i_pc    (r_pc),
        .o_inst  (dinst),
        .o_pc    (dpc),
        .o_valid (dvalid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetched, r_bubbles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetched <= '0;
            r_bubbles <= '0;
        end else begin
            r_fetched <= r_fetched + {31'd0, w_ld};
            r_bubbles <= r_bubbles + {31'd0, w_run && w_clr};
        end
    end

    assign perf_fetched = r_fetched;
    assign perf_bubbles = r_bubbles;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign fault     = r_fault;
    assign state     = r_state;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Parametrised successor to the fixed-width program-counter / PC-adder / IF-ID register trio in the 5-stage MIPS pipeline. It owns the PC, drives the instruction-memory address, and captures each fetched instruction with its PC and a valid bit into the IF/ID register. Unlike the original trio, it supports stall, flush, branch redirect, halt/resume and fault detection. It sits between the instruction memory and the decode/control unit; hazard and branch logic in ID/EX drive its control inputs.

Parameters:
XLEN, 32, datapath and PC width in bits (minimum 8).
IMEM_DEPTH, 64, instruction memory depth in 32-bit words; valid word index is 0..IMEM_DEPTH-1.
RESET_PC, 32'h0000_0064, PC loaded on reset; must be word aligned.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hold the PC and the IF/ID contents (load-use interlock).
flush  in  1  squash IF/ID: dvalid goes to 0 at the next edge.
redirect  in  1  load redirect_pc into the PC (taken branch or jump).
redirect_pc  in  XLEN  redirect target byte address.
halt  in  1  request entry to the HALT state.
resume  in  1  leave HALT when fault is 0.
imem_addr  out  XLEN  equals pc; instruction memory is combinational read.
imem_rdata  in  32  instruction word at imem_addr.
pc  out  XLEN  current fetch PC.
dinst  out  32  IF/ID instruction.
dpc  out  XLEN  IF/ID PC of dinst.
dvalid  out  1  IF/ID contents are a real instruction.
fault  out  1  sticky fetch fault.
state  out  2  FSM state: 0 BOOT, 1 RUN, 2 HALT.
perf_fetched  out  32  count of valid instructions captured into IF/ID.
perf_bubbles  out  32  count of RUN cycles in which dvalid is written as 0.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - pc = RESET_PC, dinst = 0, dpc = 0, dvalid = 0, fault = 0, state = BOOT, perf counters = 0.
- BOOT: lasts exactly one cycle. PC holds, IF/ID is not written, then the FSM goes to RUN.
- RUN: each edge applies the first matching rule, in this priority order:
  1. halt: go to HALT; PC holds; dvalid = 0.
  2. redirect with redirect_pc[1:0] != 0: fault = 1; go to HALT; PC holds; dvalid = 0.
  3. redirect: pc = redirect_pc; dvalid = 0 (wrong-path squash). Redirect overrides stall and flush.
  4. pc word index (pc >> 2) >= IMEM_DEPTH: fault = 1; go to HALT; dvalid = 0.
  5. flush: dvalid = 0. The PC advances by 4 unless stall is also high, in which case it holds.
  6. stall: PC, dinst, dpc and dvalid all hold.
  7. normal: dinst = imem_rdata; dpc = pc; dvalid = 1; pc = pc + 4.
- Fetch latency: one cycle from the PC presenting an address to dinst/dvalid.
- PC increment wraps modulo 2^XLEN; no fault is raised for the wrap itself. Range rule 4 still applies after it.
- HALT:
  - PC, dinst and dpc hold; dvalid = 0.
  - resume with fault == 0 returns to RUN on the next edge, and fetch restarts at the held PC.
  - With fault == 1, only rst exits HALT.
- dinst and dpc keep stale values while dvalid = 0; consumers must gate on dvalid.
- In BOOT and HALT, all inputs other than rst and resume are ignored.
- Perf counters wrap at 2^32. A stall cycle counts as neither a fetch nor a bubble.

Optional Feature:
FETCH_PERF_EN:
- Defined: perf_fetched and perf_bubbles are live counters as described above.
- Undefined: both ports are present but tied to 0, and no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - the fetch_state_t enumeration (BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2);
  - the default RESET_PC;
  - the INSN_W = 32 constant;
  - the NOP encoding, 32'h0000_0000.
- One natural sub-module: ifid_reg, the IF/ID register with hold, clear-valid and asynchronous reset, reusable for later pipeline registers.

Test Plan:
- Reset then release, with memory word 25 = 32'h0022_1820 and word 26 = 32'h0123_2022 -> BOOT lasts one cycle, then dpc = 100, dinst = 32'h0022_1820, dvalid = 1, then dpc = 104 with the next word.
- stall held for 2 cycles while pc = 108 -> pc stays 108, dinst/dpc/dvalid unchanged; fetch of 108 completes on the cycle after stall drops.
- redirect = 1, redirect_pc = 32'h70, asserted together with stall -> next edge gives pc = 112, dvalid = 0; the edge after gives dpc = 112, dvalid = 1.
- redirect_pc = 32'h72 -> fault = 1, state = HALT, pc holds; resume has no effect; rst clears everything.
- pc reaches 256 (word 64, with IMEM_DEPTH = 64) -> fault = 1, HALT, dvalid = 0.
- With FETCH_PERF_EN: 5 normal fetches, 1 flush, 2 stall cycles -> perf_fetched = 5, perf_bubbles = 1. Without it, both ports read 0.
